// File: rtl/alt_seq_pkg.sv
// Shared encodings for the alternating-sequence monitor.
package alt_seq_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAIL  = 2'b10
  } state_t;

  localparam int MODE_CHANGE = 0;
  localparam int MODE_COMPL  = 1;

endpackage

// File: rtl/alt_seq_sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one (load1 beats inc).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         load1,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    q <= '0;
    else if (clr)               q <= '0;
    else if (load1)             q <= W'(1);
    else if (inc && (q != '1))  q <= q + 1'b1;
  end

endmodule

// File: rtl/alt_seq_monitor.sv
// Streaming alternation checker: sticky ok, current/max run length.
// Define ALT_ERR_CNT_EN to add the saturating err_cnt violation counter and port.
module alt_seq_monitor
  import alt_seq_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8,
  parameter int MODE  = MODE_CHANGE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             ok,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run
`ifdef ALT_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic             acc, pass, started;
  logic             run_load1, run_inc;
  logic [CNT_W-1:0] run_nxt;

  // clear discards a concurrent sample
  assign acc     = in_valid & ~clear;
  assign pass    = (MODE == MODE_COMPL) ? (in_data == ~prev) : (in_data != prev);
  assign started = (state != ST_EMPTY);

  assign run_load1 = acc & (~started | ~pass);
  assign run_inc   = acc & started & pass;

  always_comb begin
    run_nxt = run_len;
    if (run_load1)                      run_nxt = ONE;
    else if (run_inc && run_len != '1)  run_nxt = run_len + 1'b1;
  end

  sat_counter #(.W(CNT_W)) u_run (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (run_inc),
    .load1 (run_load1),
    .q     (run_len)
  );

`ifdef ALT_ERR_CNT_EN
  logic viol;
  assign viol = acc & started & ~pass;

  sat_counter #(.W(CNT_W)) u_err (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (viol),
    .load1 (1'b0),
    .q     (err_cnt)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ok      <= 1'b1;
      prev    <= '0;
      max_run <= '0;
    end else if (clear) begin
      state   <= ST_EMPTY;
      ok      <= 1'b1;
      prev    <= '0;
      max_run <= '0;
    end else if (acc) begin
      prev <= in_data;
      if (run_nxt > max_run) max_run <= run_nxt;
      case (state)
        ST_EMPTY: state <= ST_RUN;
        ST_RUN: if (!pass) begin
          ok    <= 1'b0;
          state <= ST_FAIL;
        end
        ST_FAIL: state <= ST_FAIL;  // only rst/clear leave FAIL
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alt_seq_monitor.sv
// Scoreboard bench: three monitor configurations driven by directed vectors.
module tb_alt_seq_monitor;

  typedef struct {
    int k;
    int id;
    int eok;
    int erun;
    int emax;
    int eerr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] v, c, p, obs;
  logic [3:0] data;

  logic       ok0, ok1, ok2;
  logic [7:0] run0, max0, run1, max1;
  logic [2:0] run2, max2;
`ifdef ALT_ERR_CNT_EN
  logic [7:0] err0, err1;
  logic [2:0] err2;
  int         a_err;
`endif

  exp_t sb[$];
  exp_t e;
  int   checks = 0, fails = 0, step = 0;
  int   a_ok, a_run, a_max;

  always #5 clk = ~clk;

  alt_seq_monitor #(.WIDTH(1), .CNT_W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .clear(c[0]), .in_valid(v[0]), .in_data(data[0]),
    .ok(ok0), .run_len(run0), .max_run(max0)
`ifdef ALT_ERR_CNT_EN
    , .err_cnt(err0)
`endif
  );

  alt_seq_monitor #(.WIDTH(4), .CNT_W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .clear(c[1]), .in_valid(v[1]), .in_data(data),
    .ok(ok1), .run_len(run1), .max_run(max1)
`ifdef ALT_ERR_CNT_EN
    , .err_cnt(err1)
`endif
  );

  alt_seq_monitor #(.WIDTH(4), .CNT_W(3), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .clear(c[2]), .in_valid(v[2]), .in_data(data),
    .ok(ok2), .run_len(run2), .max_run(max2)
`ifdef ALT_ERR_CNT_EN
    , .err_cnt(err2)
`endif
  );

  task automatic cmp(input string nm, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", nm, id, act, exp);
    end
  endtask

  // an action captured at a posedge is observed at the following negedge
  always @(posedge clk) obs <= v | c | p;

  always @(negedge clk) begin
    if (obs != 3'b000) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_underflow obs=%b", obs);
      end else begin
        e = sb.pop_front();
        case (e.k)
          0: begin a_ok = int'(ok0); a_run = int'(run0); a_max = int'(max0); end
          1: begin a_ok = int'(ok1); a_run = int'(run1); a_max = int'(max1); end
          default: begin a_ok = int'(ok2); a_run = int'(run2); a_max = int'(max2); end
        endcase
        cmp("ok", e.id, a_ok, e.eok);
        cmp("run_len", e.id, a_run, e.erun);
        cmp("max_run", e.id, a_max, e.emax);
`ifdef ALT_ERR_CNT_EN
        case (e.k)
          0: a_err = int'(err0);
          1: a_err = int'(err1);
          default: a_err = int'(err2);
        endcase
        cmp("err_cnt", e.id, a_err, e.eerr);
`endif
      end
    end
  end

  task automatic drive(input int k, input logic vld, input logic clr, input logic prb,
                       input logic [3:0] d, input int eok, input int erun,
                       input int emax, input int eerr);
    exp_t x;
    step++;
    x.k = k; x.id = step; x.eok = eok; x.erun = erun; x.emax = emax; x.eerr = eerr;
    sb.push_back(x);
    v[k] = vld; c[k] = clr; p[k] = prb; data = d;
    @(posedge clk);
    #1;
    v[k] = 1'b0; c[k] = 1'b0; p[k] = 1'b0;
  endtask

  task automatic smp(input int k, input logic [3:0] d, input int eok, input int erun,
                     input int emax, input int eerr);
    drive(k, 1'b1, 1'b0, 1'b0, d, eok, erun, emax, eerr);
  endtask

  task automatic clr(input int k);
    drive(k, 1'b0, 1'b1, 1'b0, 4'h0, 1, 0, 0, 0);
  endtask

  task automatic hold(input int k, input int eok, input int erun, input int emax,
                      input int eerr);
    drive(k, 1'b0, 1'b0, 1'b1, 4'h0, eok, erun, emax, eerr);
  endtask

  task automatic chk_idle(input string tag);
    cmp({tag, "_ok0"}, 0, int'(ok0), 1);
    cmp({tag, "_run0"}, 0, int'(run0), 0);
    cmp({tag, "_max0"}, 0, int'(max0), 0);
    cmp({tag, "_ok2"}, 0, int'(ok2), 1);
    cmp({tag, "_run2"}, 0, int'(run2), 0);
    cmp({tag, "_max2"}, 0, int'(max2), 0);
`ifdef ALT_ERR_CNT_EN
    cmp({tag, "_err0"}, 0, int'(err0), 0);
    cmp({tag, "_err2"}, 0, int'(err2), 0);
`endif
  endtask

  initial begin
    rst = 1'b1; v = '0; c = '0; p = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    cmp("reset_ok1", 0, int'(ok1), 1);
    cmp("reset_run1", 0, int'(run1), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // WIDTH=1: clean alternation
    smp(0, 4'h0, 1, 1, 1, 0);
    smp(0, 4'h1, 1, 2, 2, 0);
    smp(0, 4'h0, 1, 3, 3, 0);
    smp(0, 4'h1, 1, 4, 4, 0);
    clr(0);
    // violation on the third sample
    smp(0, 4'h1, 1, 1, 1, 0);
    smp(0, 4'h0, 1, 2, 2, 0);
    smp(0, 4'h0, 0, 1, 2, 1);
    smp(0, 4'h1, 0, 2, 2, 1);
    hold(0, 0, 2, 2, 1);
    // clear collides with a valid sample
    clr(0);
    smp(0, 4'h0, 1, 1, 1, 0);
    smp(0, 4'h1, 1, 2, 2, 0);
    drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 1, 0, 0, 0);
    smp(0, 4'h1, 1, 1, 1, 0);
    smp(0, 4'h0, 1, 2, 2, 0);
    // repeated violations with idle gaps
    clr(0);
    smp(0, 4'h0, 1, 1, 1, 0);
    smp(0, 4'h0, 0, 1, 1, 1);
    hold(0, 0, 1, 1, 1);
    smp(0, 4'h0, 0, 1, 1, 2);
    smp(0, 4'h1, 0, 2, 2, 2);
    smp(0, 4'h1, 0, 1, 2, 3);
    hold(0, 0, 1, 2, 3);

    // WIDTH=4 complement mode
    smp(1, 4'hA, 1, 1, 1, 0);
    smp(1, 4'h5, 1, 2, 2, 0);
    smp(1, 4'hA, 1, 3, 3, 0);
    smp(1, 4'h3, 0, 1, 3, 1);
    smp(1, 4'hC, 0, 2, 3, 1);

    // WIDTH=4 change mode, same stream passes
    smp(2, 4'hA, 1, 1, 1, 0);
    smp(2, 4'h5, 1, 2, 2, 0);
    smp(2, 4'hA, 1, 3, 3, 0);
    smp(2, 4'h3, 1, 4, 4, 0);
    clr(2);
    // CNT_W=3 saturation of run_len, max_run, then err_cnt
    for (int i = 0; i < 10; i++)
      smp(2, (i % 2) ? 4'hF : 4'h0, 1, (i < 7) ? i + 1 : 7, (i < 7) ? i + 1 : 7, 0);
    smp(2, 4'hF, 0, 1, 7, 1);
    for (int j = 0; j < 8; j++)
      smp(2, 4'hF, 0, 1, 7, (j < 6) ? j + 2 : 7);

    // asynchronous reset between edges
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    smp(2, 4'h5, 1, 1, 1, 0);
    smp(2, 4'h5, 0, 1, 1, 1);
    smp(0, 4'h1, 1, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
